lcd_j80_writer: RTL and testbench

Display-side stage that consumes the pixel byte stream produced by the LCD image controller (`FIFOWe` / `RGBData`) and drives an 8080-style parallel LCD bus. It buffers bytes in an internal FIFO and emits a memory-write command at each frame start. It then replays buffered bytes as data write cycles with programmable strobe widths. It is the last stage before the panel pins.

---
 rtl/lcd_j80_writer_if.sv | 30 +++
 rtl/lcd_j80_writer.sv | 168 ++++++++++++++++
 tb/tb_lcd_j80_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_j80_writer_if.sv
// Bus bundle for the 8080 LCD writer.
// It carries the pixel byte stream coming in from the image controller
// and the parallel panel bus going out, plus the status outputs.
interface lcd_j80_writer_if #(
  parameter int FIFO_AW = 11
);
  logic             VSYNC;
  logic             FIFOWe;
  logic [7:0]       RGBData;
  logic             J80_CS;
  logic             J80_RS;
  logic             J80_WR;
  logic             J80_RD;
  logic [7:0]       J80_Data;
  logic             Busy;
  logic             Overflow;
  logic [FIFO_AW:0] Level;

  // The image-controller side: it drives the stream and watches the bus.
  modport master (
    output VSYNC, FIFOWe, RGBData,
    input  J80_CS, J80_RS, J80_WR, J80_RD, J80_Data, Busy, Overflow, Level
  );

  // The writer itself: it takes the stream and drives the panel pins.
  modport slave (
    input  VSYNC, FIFOWe, RGBData,
    output J80_CS, J80_RS, J80_WR, J80_RD, J80_Data, Busy, Overflow, Level
  );
endinterface

// File: rtl/lcd_j80_writer.sv
// 8080-style LCD bus writer.
// Pixel bytes are buffered in a first-word-fall-through FIFO. Each frame
// start flushes the FIFO and queues a memory-write command. Buffered bytes
// are then replayed as data writes with programmable low/high strobe widths.
module lcd_j80_writer #(
  parameter int         FIFO_AW   = 11,
  parameter int         WR_LOW    = 1,
  parameter int         WR_HIGH   = 1,
  parameter logic [7:0] CMD_MEMWR = 8'h2C
) (
  input  logic             CLK,
  input  logic             nRST,
  lcd_j80_writer_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  localparam int MAXW  = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW    = $clog2(MAXW + 1);

  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [LW-1:0]      LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]      FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0]      PH_ONE   = CW'(1);
  localparam logic [CW-1:0]      LO_LAST  = CW'(WR_LOW - 1);
  localparam logic [CW-1:0]      HI_LAST  = CW'(WR_HIGH - 1);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t             state_q;
  logic [CW-1:0]      phase_q;
  logic               cmd_pending_q;
  logic               cs_q;
  logic               wr_q;
  logic               rs_q;
  logic [7:0]         data_q;
  logic               vsync_q;
  logic               overflow_q;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;

  logic               flush;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [7:0]         head;
  logic               load_now;
  logic               load_cmd;
  logic               load_data;

  assign flush = bus.VSYNC && !vsync_q;
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign head  = mem[rd_ptr_q];

  // Load decisions happen in IDLE or on the final high-phase cycle. A pending
  // command wins over data; no data byte is popped while a flush is in
  // progress, so a stale byte of the old frame can never follow the flush.
  always_comb begin
    load_now  = (state_q == IDLE) || ((state_q == WR_HI) && (phase_q == HI_LAST));
    load_cmd  = load_now && cmd_pending_q;
    load_data = load_now && !cmd_pending_q && !empty && !flush;
    pop       = load_data;
    push      = bus.FIFOWe && !full && !flush;
  end

  // Next pointer and occupancy values; a flush clears everything at once.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= bus.RGBData;
  end

  // Pointers, occupancy, the VSYNC edge detector and the sticky drop flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      vsync_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      vsync_q  <= bus.VSYNC;
      if (bus.FIFOWe && full && !flush) overflow_q <= 1'b1;
    end
  end

  // Bus-cycle FSM with registered pins. Data and RS are only touched on a
  // load, so they stay stable across the whole low and high window.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      cmd_pending_q <= 1'b0;
      cs_q          <= 1'b1;
      wr_q          <= 1'b1;
      rs_q          <= 1'b1;
      data_q        <= '0;
    end else begin
      if (flush) begin
        cmd_pending_q <= 1'b1;
      end else if (load_cmd) begin
        cmd_pending_q <= 1'b0;
      end

      if (load_now) begin
        if (load_cmd || load_data) begin
          state_q <= WR_LO;
          phase_q <= '0;
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          rs_q    <= load_data;
          data_q  <= load_cmd ? CMD_MEMWR : head;
        end else begin
          state_q <= IDLE;
          phase_q <= '0;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
        end
      end else if (state_q == WR_LO) begin
        if (phase_q == LO_LAST) begin
          state_q <= WR_HI;
          phase_q <= '0;
          wr_q    <= 1'b1;
        end else begin
          phase_q <= phase_q + PH_ONE;
        end
      end else begin
        phase_q <= phase_q + PH_ONE;
      end
    end
  end

  assign bus.J80_CS   = cs_q;
  assign bus.J80_WR   = wr_q;
  assign bus.J80_RD   = 1'b1;
  assign bus.J80_RS   = rs_q;
  assign bus.J80_Data = data_q;
  assign bus.Overflow = overflow_q;
  assign bus.Level    = level_q;
  assign bus.Busy     = (state_q != IDLE) || !empty || cmd_pending_q;

endmodule

// File: tb/tb_lcd_j80_writer.sv
// Bench for the 8080 LCD writer.
// Instance A uses the default geometry; instance B has a 16-byte FIFO and
// 3/2 strobe widths for the overflow, mid-cycle reset and width scenarios.
module tb_lcd_j80_writer;

  logic clk;
  logic rstA_n;
  logic rstB_n;

  lcd_j80_writer_if #(.FIFO_AW(11)) ifA ();
  lcd_j80_writer_if #(.FIFO_AW(4))  ifB ();

  lcd_j80_writer #(.FIFO_AW(11), .WR_LOW(1), .WR_HIGH(1), .CMD_MEMWR(8'h2C)) dutA (
    .CLK  (clk),
    .nRST (rstA_n),
    .bus  (ifA.slave)
  );

  lcd_j80_writer #(.FIFO_AW(4), .WR_LOW(3), .WR_HIGH(2), .CMD_MEMWR(8'h2C)) dutB (
    .CLK  (clk),
    .nRST (rstB_n),
    .bus  (ifB.slave)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [8:0] expA [$];
  logic [8:0] expB [$];
  logic [8:0] gotB [$];
  bit         sbB = 1'b0;

  int   lowA, lowB, hiB;
  logic prevWrA, prevWrB;

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte for one cycle and records it as an expected data word.
  task automatic applyStimulus(input bit toB, input logic [7:0] d);
    if (toB) begin
      ifB.FIFOWe  = 1'b1;
      ifB.RGBData = d;
      expB.push_back({1'b1, d});
    end else begin
      ifA.FIFOWe  = 1'b1;
      ifA.RGBData = d;
      expA.push_back({1'b1, d});
    end
    @(negedge clk);
  endtask

  task automatic waitDrain(input bit onB, input int limit);
    int n = 0;
    while (n < limit && (onB ? (expB.size() != 0 || ifB.Busy) : (expA.size() != 0 || ifA.Busy))) begin
      @(negedge clk);
      n++;
    end
    checkOutput(onB ? "B_drain" : "A_drain", 32'(n < limit), 32'd1);
  endtask

  // Monitor A: every completed write (WR rising with CS low) is compared
  // against the next expected word, along with its low-phase width.
  always @(negedge clk) begin
    if (!rstA_n) begin
      prevWrA = 1'b1;
      lowA    = 0;
    end else begin
      if (ifA.J80_WR == 1'b0) lowA++;
      if (prevWrA == 1'b0 && ifA.J80_WR == 1'b1 && ifA.J80_CS == 1'b0) begin
        checkOutput("A_wr_low_width", 32'(lowA), 32'd1);
        if (expA.size() == 0) begin
          checkOutput("A_unexpected_write", 32'({ifA.J80_RS, ifA.J80_Data}), 32'h1FF);
        end else begin
          logic [8:0] e;
          e = expA.pop_front();
          checkOutput("A_bus_word", 32'({ifA.J80_RS, ifA.J80_Data}), 32'(e));
        end
        lowA = 0;
      end
      prevWrA = ifA.J80_WR;
    end
  end

  // Monitor B: logs every completed write, checks low 3 / high 2 widths
  // and, when enabled, compares against the expected queue.
  always @(negedge clk) begin
    if (!rstB_n) begin
      prevWrB = 1'b1;
      lowB    = 0;
      hiB     = 0;
    end else begin
      if (ifB.J80_CS == 1'b1) hiB = 0;
      if (prevWrB == 1'b1 && ifB.J80_WR == 1'b0) begin
        if (hiB != 0) checkOutput("B_wr_high_width", 32'(hiB), 32'd2);
        hiB = 0;
      end
      if (ifB.J80_WR == 1'b0) lowB++;
      else if (ifB.J80_CS == 1'b0) hiB++;
      if (prevWrB == 1'b0 && ifB.J80_WR == 1'b1 && ifB.J80_CS == 1'b0) begin
        checkOutput("B_wr_low_width", 32'(lowB), 32'd3);
        lowB = 0;
        gotB.push_back({ifB.J80_RS, ifB.J80_Data});
        if (sbB) begin
          if (expB.size() == 0) begin
            checkOutput("B_unexpected_write", 32'({ifB.J80_RS, ifB.J80_Data}), 32'h1FF);
          end else begin
            logic [8:0] e;
            e = expB.pop_front();
            checkOutput("B_bus_word", 32'({ifB.J80_RS, ifB.J80_Data}), 32'(e));
          end
        end
      end
      prevWrB = ifB.J80_WR;
    end
  end

  // Directed sequence: reset, frame command, burst, flush, overflow, reset.
  initial begin
    int         n;
    int         peakA;
    int         peakB;
    bit         ordered;
    logic [8:0] frontA;

    rstA_n = 1'b0;
    rstB_n = 1'b0;
    ifA.VSYNC = 1'b0; ifA.FIFOWe = 1'b0; ifA.RGBData = 8'h00;
    ifB.VSYNC = 1'b0; ifB.FIFOWe = 1'b0; ifB.RGBData = 8'h00;

    repeat (3) @(negedge clk);
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("A_rst_cs",   32'(ifA.J80_CS),   32'd1);
    checkOutput("A_rst_wr",   32'(ifA.J80_WR),   32'd1);
    checkOutput("A_rst_rd",   32'(ifA.J80_RD),   32'd1);
    checkOutput("A_rst_rs",   32'(ifA.J80_RS),   32'd1);
    checkOutput("A_rst_data", 32'(ifA.J80_Data), 32'h00);
    checkOutput("A_rst_busy", 32'(ifA.Busy),     32'd0);
    checkOutput("A_rst_ovf",  32'(ifA.Overflow), 32'd0);
    checkOutput("A_rst_lvl",  32'(ifA.Level),    32'd0);
    checkOutput("B_rst_cs",   32'(ifB.J80_CS),   32'd1);
    checkOutput("B_rst_busy", 32'(ifB.Busy),     32'd0);

    $display("[TB] frame command then first pixel");
    ifA.VSYNC = 1'b1;
    expA.push_back(9'h02C);
    @(negedge clk);
    ifA.VSYNC = 1'b0;
    applyStimulus(1'b0, 8'hA5);
    ifA.FIFOWe = 1'b0;
    waitDrain(1'b0, 50);

    $display("[TB] burst of 1600 bytes");
    peakA = 0;
    for (int i = 0; i < 1600; i++) begin
      applyStimulus(1'b0, 8'(i % 64));
      if (int'(ifA.Level) > peakA) peakA = int'(ifA.Level);
    end
    ifA.FIFOWe = 1'b0;
    checkOutput("A_peak_level_lo", 32'(peakA >= 799), 32'd1);
    checkOutput("A_peak_level_hi", 32'(peakA <= 801), 32'd1);
    waitDrain(1'b0, 4000);
    checkOutput("A_overflow_clear", 32'(ifA.Overflow), 32'd0);

    $display("[TB] flush mid-stream");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'(8'h80 + i));
    ifA.FIFOWe = 1'b0;
    n = 0;
    while (n < 20 && !(ifA.J80_WR == 1'b0 && ifA.J80_RS == 1'b1)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("A_inflight_found", 32'(n < 20), 32'd1);
    frontA = (expA.size() != 0) ? expA[0] : 9'h1FF;
    checkOutput("A_inflight_byte", 32'({ifA.J80_RS, ifA.J80_Data}), 32'(frontA));
    expA.delete();
    expA.push_back(frontA);
    expA.push_back(9'h02C);
    ifA.VSYNC = 1'b1;
    @(negedge clk);
    ifA.VSYNC = 1'b0;
    checkOutput("A_level_after_flush", 32'(ifA.Level), 32'd0);
    checkOutput("A_inflight_held", 32'({ifA.J80_RS, ifA.J80_Data}), 32'(frontA));
    @(negedge clk);
    checkOutput("A_cmd_after_flush", 32'({ifA.J80_WR, ifA.J80_RS, ifA.J80_Data}), 32'h02C);
    waitDrain(1'b0, 50);

    $display("[TB] overflow on 16-deep FIFO");
    sbB = 1'b0;
    gotB.delete();
    peakB = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (int'(ifB.Level) > peakB) peakB = int'(ifB.Level);
    end
    ifB.FIFOWe = 1'b0;
    expB.delete();
    waitDrain(1'b1, 400);
    checkOutput("B_overflow_set", 32'(ifB.Overflow), 32'd1);
    checkOutput("B_peak_full", 32'(peakB), 32'd16);
    checkOutput("B_bytes_missing", 32'(gotB.size() < 40), 32'd1);
    checkOutput("B_first_byte", 32'((gotB.size() != 0) ? gotB[0] : 9'h000), 32'h100);
    ordered = 1'b1;
    for (int k = 0; k < gotB.size(); k++) begin
      if (gotB[k][8] != 1'b1) ordered = 1'b0;
      if (k > 0 && gotB[k] <= gotB[k-1]) ordered = 1'b0;
    end
    checkOutput("B_order", 32'(ordered), 32'd1);

    $display("[TB] reset during low phase, then 3/2 strobes");
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    ifB.FIFOWe = 1'b0;
    expB.delete();
    n = 0;
    while (n < 20 && ifB.J80_WR != 1'b0) begin
      @(negedge clk);
      n++;
    end
    checkOutput("B_low_found", 32'(n < 20), 32'd1);
    #2;
    rstB_n = 1'b0;
    #1;
    checkOutput("B_midrst_wr",  32'(ifB.J80_WR),   32'd1);
    checkOutput("B_midrst_cs",  32'(ifB.J80_CS),   32'd1);
    checkOutput("B_midrst_ovf", 32'(ifB.Overflow), 32'd0);
    checkOutput("B_midrst_lvl", 32'(ifB.Level),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rstB_n = 1'b1;
    sbB = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i));
    ifB.FIFOWe = 1'b0;
    waitDrain(1'b1, 200);
    checkOutput("B_ovf_after_rst", 32'(ifB.Overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
